// File: rtl/trackball_quad_gen.sv
// Converts signed mouse deltas into rate-limited quadrature pairs for the LETA trackball inputs.
// Build option: define TB_INVERT_Y_EN to negate mouse_dy before it is accumulated.
module trackball_quad_gen #(
  parameter int STEP_DIV = 2000,
  parameter int DELTA_W  = 9,
  parameter int ACC_W    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mouse_strobe,
  input  logic [DELTA_W-1:0] mouse_dx,
  input  logic [DELTA_W-1:0] mouse_dy,
  output logic               h_qa,
  output logic               h_qb,
  output logic               v_qa,
  output logic               v_qb,
  output logic               moving
);

  localparam int DIV_W = $clog2(STEP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W+1)'(2**(ACC_W-1) - 1);
  localparam logic signed [ACC_W:0] SUM_MIN = -SUM_MAX;
  localparam logic signed [ACC_W:0] SUM_ONE = (ACC_W+1)'(1);

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  logic [DIV_W-1:0] div_q, div_d;
  logic [ACC_W-1:0] accX_q, accX_d;
  logic [ACC_W-1:0] accY_q, accY_d;
  phase_t           hPhase_q, hPhase_d;
  phase_t           vPhase_q, vPhase_d;
  logic             moving_q;

  logic                  tick;
  logic                  fwdX, bwdX, fwdY, bwdY;
  logic signed [ACC_W:0] deltaX, deltaY;
  logic signed [ACC_W:0] sumX, sumY;

  function automatic logic [ACC_W-1:0] satAcc(input logic signed [ACC_W:0] s);
    if (s > SUM_MAX) begin
      return SUM_MAX[ACC_W-1:0];
    end else if (s < SUM_MIN) begin
      return SUM_MIN[ACC_W-1:0];
    end else begin
      return s[ACC_W-1:0];
    end
  endfunction

  function automatic phase_t advance(input phase_t p, input logic fwd, input logic bwd);
    phase_t n;
    n = p;
    case (p)
      PH_00:   n = fwd ? PH_01 : (bwd ? PH_10 : PH_00);
      PH_01:   n = fwd ? PH_11 : (bwd ? PH_00 : PH_01);
      PH_11:   n = fwd ? PH_10 : (bwd ? PH_01 : PH_11);
      PH_10:   n = fwd ? PH_00 : (bwd ? PH_11 : PH_10);
      default: n = PH_00;
    endcase
    return n;
  endfunction

  assign tick = (div_q == DIV_LAST);

  // Deltas are widened to the sum width; an inverted -2^(DELTA_W-1) becomes positive, not wrapped.
`ifdef TB_INVERT_Y_EN
  logic [DELTA_W:0] dyNeg;
  assign dyNeg = -{mouse_dy[DELTA_W-1], mouse_dy};
`endif

  always_comb begin
    deltaX = '0;
    deltaY = '0;
    if (mouse_strobe) begin
      deltaX = {{(ACC_W+1-DELTA_W){mouse_dx[DELTA_W-1]}}, mouse_dx};
`ifdef TB_INVERT_Y_EN
      deltaY = {{(ACC_W-DELTA_W){dyNeg[DELTA_W]}}, dyNeg};
`else
      deltaY = {{(ACC_W+1-DELTA_W){mouse_dy[DELTA_W-1]}}, mouse_dy};
`endif
    end
  end

  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);

    fwdX = tick && !accX_q[ACC_W-1] && (accX_q != '0);
    bwdX = tick && accX_q[ACC_W-1];
    fwdY = tick && !accY_q[ACC_W-1] && (accY_q != '0);
    bwdY = tick && accY_q[ACC_W-1];

    // Delta and drain step land in the same update, so a coincident strobe loses nothing.
    sumX = {accX_q[ACC_W-1], accX_q} + deltaX;
    if (fwdX) sumX = sumX - SUM_ONE;
    if (bwdX) sumX = sumX + SUM_ONE;
    sumY = {accY_q[ACC_W-1], accY_q} + deltaY;
    if (fwdY) sumY = sumY - SUM_ONE;
    if (bwdY) sumY = sumY + SUM_ONE;

    accX_d   = satAcc(sumX);
    accY_d   = satAcc(sumY);
    hPhase_d = advance(hPhase_q, fwdX, bwdX);
    vPhase_d = advance(vPhase_q, fwdY, bwdY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      accX_q   <= '0;
      accY_q   <= '0;
      hPhase_q <= PH_00;
      vPhase_q <= PH_00;
      moving_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      accX_q   <= accX_d;
      accY_q   <= accY_d;
      hPhase_q <= hPhase_d;
      vPhase_q <= vPhase_d;
      moving_q <= (accX_d != '0) || (accY_d != '0);
    end
  end

  assign {h_qa, h_qb} = hPhase_q;
  assign {v_qa, v_qb} = vPhase_q;
  assign moving       = moving_q;

endmodule
